// File: rtl/neuron_accumulator.sv
// neuron_accumulator: per-neuron membrane potential storage with weighted-spike accumulation and a leak/threshold sweep.
// Optional leak enabled by defining NEURON_LEAK_EN; otherwise swept potentials pass through unmodified.
module neuron_accumulator #(
  parameter int NEURONS = 16,
  parameter int ID_W = 4,
  parameter int LEAK_SHIFT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ID_W-1:0]    in_neuron_id,
  input  logic signed [31:0] in_weight,
  input  logic               timestep_start,
  input  logic signed [31:0] v_threshold,
  output logic signed [31:0] adder_potential,
  output logic               spiked,
  output logic               out_valid,
  output logic [ID_W-1:0]    out_neuron_id,
  input  logic signed [31:0] potential_to_mem,
  output logic               sweep_done,
  output logic [ID_W:0]      spike_count,
  output logic               overrun
);
  localparam logic [1:0] ACCUM = 2'd0, SWEEP = 2'd1, DONE = 2'd2;
`ifdef NEURON_LEAK_EN
  localparam bit LEAK_EN = 1'b1;
`else
  localparam bit LEAK_EN = 1'b0;
`endif
  logic [1:0] state;
  logic [ID_W-1:0] idx;
  logic [ID_W:0] counter;
  logic signed [31:0] pot [NEURONS];
  logic signed [31:0] cur, leaked, sel, sat_sum;
  logic signed [32:0] sum;
  logic in_sweep, hit;
  always_comb begin
    in_sweep = state == SWEEP;
    cur = pot[idx];
    leaked = LEAK_EN ? cur - (cur >>> LEAK_SHIFT) : cur;
    adder_potential = in_sweep ? leaked : '0;
    spiked = in_sweep && (leaked >= v_threshold);
    out_valid = in_sweep;
    out_neuron_id = in_sweep ? idx : '0;
    in_ready = state == ACCUM;
    sweep_done = state == DONE;
    hit = in_valid && (32'(in_neuron_id) < NEURONS);
    sel = pot[in_neuron_id];
    sum = {in_weight[31], in_weight} + {sel[31], sel};
    // a carry disagreeing with the sign bit means the 32-bit result overflowed
    sat_sum = (sum[32] != sum[31]) ? (sum[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF) : sum[31:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACCUM;
      idx <= '0;
      counter <= '0;
      spike_count <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < NEURONS; i++) pot[i] <= '0;
    end else begin
      if (timestep_start && state != ACCUM) overrun <= 1'b1;
      if (state == ACCUM) begin
        if (hit) pot[in_neuron_id] <= sat_sum;
        if (timestep_start) begin
          state <= SWEEP;
          idx <= '0;
          counter <= '0;
        end
      end else if (state == SWEEP) begin
        pot[idx] <= potential_to_mem;
        counter <= counter + {{ID_W{1'b0}}, spiked};
        idx <= idx + 1'b1;
        if (idx == ID_W'(NEURONS - 1)) state <= DONE;
      end else begin
        spike_count <= counter;
        state <= ACCUM;
      end
    end
  end
endmodule

// File: doc/neuron_accumulator.md
Name: neuron_accumulator

Overview:
- Upstream stage of the neuron potential reset logic: owns per-neuron membrane potentials for one core.
- Accumulates weighted input spikes during a timestep; on timestep boundary sweeps all neurons, applying leak and threshold compare.
- Drives adder_potential and spiked to the reset stage and writes the returned potential_to_mem back into its own storage.

Parameters:
- NEURONS, 16, number of neurons held (register-file depth)
- ID_W, 4, neuron index width (2**ID_W >= NEURONS)
- LEAK_SHIFT, 3, leak = potential >>> LEAK_SHIFT (arithmetic)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  weighted spike event valid
- in_ready  out  1  block accepts event this cycle
- in_neuron_id  in  ID_W  target neuron of event
- in_weight  in  32  signed synaptic weight
- timestep_start  in  1  single-cycle pulse: close accumulation, start sweep
- v_threshold  in  32  signed firing threshold, stable during sweep
- adder_potential  out  32  post-leak potential of neuron under sweep
- spiked  out  1  adder_potential >= v_threshold (signed)
- out_valid  out  1  adder_potential/spiked/out_neuron_id valid this cycle
- out_neuron_id  out  ID_W  neuron under sweep
- potential_to_mem  in  32  returned potential from reset stage, same cycle
- sweep_done  out  1  one-cycle pulse after last neuron written
- spike_count  out  ID_W+1  spikes in last completed sweep
- overrun  out  1  sticky: timestep_start arrived while not ACCUM

Behaviour:
- Reset (rst_n=0 at edge): state=ACCUM, all potentials=0, idx=0, spike_count=0, overrun=0, sweep_done=0; combinational outputs then out_valid=0, spiked=0, adder_potential=0, out_neuron_id=0, in_ready=1. Reset mid-sweep abandons sweep; no partial writes after reset edge.
- States: ACCUM -> SWEEP -> DONE -> ACCUM.
- ACCUM: in_ready=1. On in_valid: pot[id] <= sat32(pot[id] + in_weight), signed saturation to [-2^31, 2^31-1]. id >= NEURONS: event consumed, dropped. timestep_start: go to SWEEP, idx<=0, spike counter cleared; an in_valid event in that same cycle is still applied first.
- SWEEP: in_ready=0. Each cycle, combinationally: out_valid=1, out_neuron_id=idx, adder_potential=pot[idx]-(pot[idx]>>>LEAK_SHIFT), spiked per compare. At edge: pot[idx]<=potential_to_mem, counter += spiked, idx++. After idx=NEURONS-1 -> DONE. Sweep latency exactly NEURONS cycles.
- DONE: one cycle; sweep_done=1, spike_count<=counter (held until next DONE), in_ready=0, out_valid=0; next ACCUM.
- Outside SWEEP: adder_potential=0, spiked=0, out_neuron_id=0.
- timestep_start in SWEEP or DONE: ignored, overrun<=1 (cleared only by reset).
- Negative potentials leak toward 0 (arithmetic shift); -1 >>> k = -1, so -1 leaks to 0.

Optional Feature:
- Macro NEURON_LEAK_EN. Defined: leak applied as above. Undefined: adder_potential=pot[idx] unmodified; LEAK_SHIFT unused; all else identical.

Test Plan:
- Reset: hold rst_n=0 two cycles -> in_ready=1, out_valid=0, spike_count=0, overrun=0; sweep with v_threshold=1 (potential_to_mem looped from reset model) -> spike_count=0.
- Accumulate: NEURONS=4, weights 60,60 to id 2, threshold 100, leak on -> sweep id2 adder_potential=105, spiked=1, reset model writes 5; other ids 0, spike_count=1; second sweep id2 shows 5, spiked=0.
- Saturation: pot[0]=0x7FFFFFF0, add 0x100 -> pot[0]=0x7FFFFFFF; add -0x80000000 twice from 0 -> 0x80000000.
- Simultaneous: in_valid(id1,+50) with timestep_start -> in_ready=1, event applied; id1 swept with 50-6=44.
- Overrun/timing: timestep_start again 2 cycles into sweep -> ignored, overrun=1; sweep_done rises exactly NEURONS+1 cycles after first timestep_start; in_ready=0 throughout.
- Bad id and reset mid-sweep: in_neuron_id=7 (NEURONS=4) -> no potential changes; rst_n=0 at idx=2 -> all pots 0, state ACCUM next cycle.
